regs_mp: RTL and testbench
==========================

REGS_MP -- requirements
Module: regs_mp

Interface
Parameters (name, default, meaning):
REQ-001 W, 32, data width in bits.
REQ-002 NREG, 32, number of architectural registers; power of two, >=4; AW = log2(NREG).
REQ-003 LANES, 2, issue/writeback lanes; 1..4; lane 0 is oldest in program order.

Ports (name  direction  width  meaning):
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rs  in  1  reset, asynchronous, active-low.
REQ-006 ra_a, ra_b  in  LANES*AW  per-lane source addresses, lane i at bits [i*AW +: AW].
REQ-007 rd_a, rd_b  out  LANES*W  per-lane registered read data.
REQ-008 iss_v  in  LANES  per-lane issue request.
REQ-009 iss_rd  in  LANES*AW  per-lane destination register of issuing instruction.
REQ-010 stall  out  LANES  combinational per-lane stall; an issue is accepted when iss_v[i] & ~stall[i].
REQ-011 wb_v  in  LANES  per-lane writeback valid.
REQ-012 wb_rd  in  LANES*AW  per-lane writeback address.
REQ-013 wb_data  in  LANES*W  per-lane writeback data.
REQ-014 busy  out  NREG  scoreboard pending bits, registered.

Function
REQ-015 Register 0 SHALL read as zero always; writes and busy-set to register 0 SHALL be ignored.
REQ-016 Reads SHALL have 1-cycle latency: rd_a/rd_b at edge N+1 reflect the register value after all writebacks at edge N, i.e. same-cycle writeback data SHALL be bypassed to the read.
REQ-017 When several lanes write the same register in one cycle, the highest-numbered lane SHALL win, for both storage and bypass.
REQ-018 A writeback with wb_v[i]=1 SHALL write wb_data and clear busy[wb_rd] at the edge, regardless of the prior busy value.
REQ-019 stall[i] SHALL be 1 when iss_v[i]=1 and any of: busy[ra_a[i]], busy[ra_b[i]] or busy[iss_rd[i]] is set and not cleared by a writeback in the same cycle; or a lower lane j<i issues accepted this cycle with iss_rd[j] (nonzero) equal to ra_a[i], ra_b[i] or iss_rd[i]; or any lower lane j<i has stall[j]=1 (in-order issue).
REQ-020 stall[i] SHALL be 0 when iss_v[i]=0, except as forced by a stalled lower lane.
REQ-021 Accepted issue with iss_rd != 0 SHALL set busy[iss_rd] at the edge.
REQ-022 Same register set by an accepted issue and cleared by a writeback in the same cycle: set SHALL win (busy=1 after edge).
REQ-023 Busy for register 0 SHALL always be 0; address 0 never causes a stall.
REQ-024 No state SHALL change on an edge other than through REQ-016..REQ-022.

Reset
REQ-025 While rs=0, all registers, busy, and rd_a/rd_b SHALL be 0, asynchronously, without waiting for clk.
REQ-026 Writebacks and issues presented while rs=0 SHALL be discarded; first accepted operation occurs on the first rising edge with rs=1.
REQ-027 Reset asserted mid-operation SHALL clear all pending busy bits; later writebacks to formerly busy registers SHALL still write data normally.

Verification
REQ-028 Reset then read r5 on both lanes -> rd_a = rd_b = 0, busy = 0, stall = 0.
REQ-029 Lane0 wb r3 = 0xDEADBEEF while lane1 reads r3 same cycle -> next cycle rd_a[lane1] = 0xDEADBEEF (bypass).
REQ-030 Lane0 and lane1 both wb r7 (0x11111111, 0x22222222) -> r7 reads 0x22222222.
REQ-031 Lane0 issues rd=r4 (accepted), lane1 issues reading r4 same cycle -> stall = 2'b10; next cycle busy[4]=1; wb r4 -> busy[4] cleared in same edge, lane1 unstalls in the wb cycle.
REQ-032 Issue rd=r9 in the same cycle as wb r9 -> busy[9]=1 after edge, data = wb value; write r0 = 0xFFFFFFFF -> reads 0, busy[0]=0.
REQ-033 Set busy r2, r6, assert rs low between edges -> busy, outputs go to 0 immediately; after release, issue to r2 accepted without stall.

Source files
------------

// File: rtl/regs_mp.sv
// regs_mp: multi-lane register file with an issue scoreboard.
//
// Parameters:
//   W      data width
//   NREG   number of architectural registers (power of two, >= 4)
//   LANES  issue/writeback lanes (1..4); lane 0 is oldest in program order
//
// Ports:
//   clk             rising-edge clock
//   rs              asynchronous active-low reset
//   ra_a, ra_b      per-lane source addresses (lane i at [i*AW +: AW])
//   rd_a, rd_b      per-lane registered read data, writeback-bypassed
//   iss_v, iss_rd   per-lane issue request and destination register
//   stall           combinational per-lane stall (accept = iss_v & ~stall)
//   wb_v, wb_rd,
//   wb_data         per-lane writeback valid, address, data
//   busy            registered scoreboard pending bits
module regs_mp #(
  parameter int W     = 32,
  parameter int NREG  = 32,
  parameter int LANES = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rs,
  input  logic [LANES*AW-1:0] ra_a,
  input  logic [LANES*AW-1:0] ra_b,
  output logic [LANES*W-1:0]  rd_a,
  output logic [LANES*W-1:0]  rd_b,
  input  logic [LANES-1:0]    iss_v,
  input  logic [LANES*AW-1:0] iss_rd,
  output logic [LANES-1:0]    stall,
  input  logic [LANES-1:0]    wb_v,
  input  logic [LANES*AW-1:0] wb_rd,
  input  logic [LANES*W-1:0]  wb_data,
  output logic [NREG-1:0]     busy
);

  logic [W-1:0]     regs [NREG];
  logic [W-1:0]     nxt  [NREG];
  logic [NREG-1:0]  clr;
  logic [NREG-1:0]  set;
  logic [NREG-1:0]  eff_busy;
  logic [NREG-1:0]  busy_nxt;
  logic [LANES-1:0] stl;

  // Register contents after this cycle's writebacks. Lanes are applied in
  // ascending order so the highest lane wins; the same array feeds both the
  // storage update and the read bypass.
  always_comb begin : wb_merge
    for (int unsigned r = 0; r < NREG; r++) nxt[r] = regs[r];
    clr = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wb_v[i]) begin
        clr[wb_rd[i*AW +: AW]] = 1'b1;
        if (wb_rd[i*AW +: AW] != '0) nxt[wb_rd[i*AW +: AW]] = wb_data[i*W +: W];
      end
    end
    nxt[0] = '0;
  end

  // A pending bit cleared by a writeback this cycle no longer blocks issue.
  assign eff_busy = busy & ~clr;

  always_comb begin : issue_check
    logic           blocked;
    logic           hazard;
    logic [AW-1:0]  sa, sb, sd, dj;
    stl     = '0;
    set     = '0;
    blocked = 1'b0;
    hazard  = 1'b0;
    sa      = '0;
    sb      = '0;
    sd      = '0;
    dj      = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sa = ra_a[i*AW +: AW];
      sb = ra_b[i*AW +: AW];
      sd = iss_rd[i*AW +: AW];
      hazard = eff_busy[sa] | eff_busy[sb] | eff_busy[sd];
      for (int unsigned j = 0; j < i; j++) begin
        dj = iss_rd[j*AW +: AW];
        if (iss_v[j] && !stl[j] && dj != '0 && (dj == sa || dj == sb || dj == sd))
          hazard = 1'b1;
      end
      stl[i]  = blocked | (iss_v[i] & hazard);
      blocked = stl[i];
      if (iss_v[i] && !stl[i] && sd != '0) set[sd] = 1'b1;
    end
  end

  assign stall = stl;

  // Set beats clear when both hit the same register in one cycle.
  always_comb begin
    busy_nxt    = eff_busy | set;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
      busy <= '0;
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= nxt[r];
      busy <= busy_nxt;
      for (int unsigned i = 0; i < LANES; i++) begin
        rd_a[i*W +: W] <= nxt[ra_a[i*AW +: AW]];
        rd_b[i*W +: W] <= nxt[ra_b[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regs_mp.sv
// tb_regs_mp: scoreboard bench for regs_mp. A driver issues stimulus and
// pushes expected stall (same cycle) and expected read data/busy (next
// cycle) into queues; a monitor pops and compares on each falling edge.
module tb_regs_mp;
  localparam int W     = 32;
  localparam int NREG  = 32;
  localparam int LANES = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rs  = 1'b1;
  logic [LANES*AW-1:0] ra_a = '0, ra_b = '0, iss_rd = '0, wb_rd = '0;
  logic [LANES-1:0]    iss_v = '0, wb_v = '0;
  logic [LANES*W-1:0]  wb_data = '0;
  logic [LANES*W-1:0]  rd_a, rd_b;
  logic [LANES-1:0]    stall;
  logic [NREG-1:0]     busy;

  regs_mp #(.W(W), .NREG(NREG), .LANES(LANES)) dut (
    .clk(clk), .rs(rs), .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b),
    .iss_v(iss_v), .iss_rd(iss_rd), .stall(stall), .wb_v(wb_v),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct { int due; logic [LANES-1:0] s; } st_t;
  typedef struct { int due; logic [LANES*W-1:0] a; logic [LANES*W-1:0] b; logic [NREG-1:0] bz; } out_t;
  st_t  sq[$];
  out_t oq[$];

  // Reference state: architectural registers and pending flags.
  logic [W-1:0] mreg [NREG];
  bit           mbusy [NREG];

  initial begin
    for (int r = 0; r < NREG; r++) begin mreg[r] = '0; mbusy[r] = 0; end
  end

  function automatic logic [LANES*AW-1:0] pa(input int l0, input int l1);
    pa = {AW'(l1), AW'(l0)};
  endfunction

  function automatic logic [LANES*W-1:0] pd(input logic [W-1:0] d0, input logic [W-1:0] d1);
    pd = {d1, d0};
  endfunction

  task automatic step(input logic [LANES*AW-1:0] a, input logic [LANES*AW-1:0] b,
                      input logic [LANES-1:0] iv, input logic [LANES*AW-1:0] ird,
                      input logic [LANES-1:0] wv, input logic [LANES*AW-1:0] wrd,
                      input logic [LANES*W-1:0] wd);
    logic [LANES-1:0] es;
    logic [AW-1:0]    ad [3];
    logic [AW-1:0]    dst [$];
    logic [AW-1:0]    w;
    bit               blocked, haz, cleared;
    st_t              se;
    out_t             oe;
    @(posedge clk); #1;
    ra_a = a; ra_b = b; iss_v = iv; iss_rd = ird; wb_v = wv; wb_rd = wrd; wb_data = wd;
    es = '0; blocked = 0; dst.delete();
    for (int i = 0; i < LANES; i++) begin
      ad[0] = a[i*AW +: AW]; ad[1] = b[i*AW +: AW]; ad[2] = ird[i*AW +: AW];
      if (blocked) es[i] = 1'b1;
      else if (iv[i]) begin
        haz = 0;
        for (int k = 0; k < 3; k++) begin
          if (ad[k] == 0) continue;
          cleared = 0;
          for (int l = 0; l < LANES; l++) if (wv[l] && wrd[l*AW +: AW] == ad[k]) cleared = 1;
          if (mbusy[ad[k]] && !cleared) haz = 1;
          foreach (dst[q]) if (dst[q] == ad[k]) haz = 1;
        end
        if (haz) begin es[i] = 1'b1; blocked = 1; end
        else if (ad[2] != 0) dst.push_back(ad[2]);
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (wv[l]) begin
        w = wrd[l*AW +: AW];
        if (w != 0) mreg[w] = wd[l*W +: W];
        mbusy[w] = 0;
      end
    end
    foreach (dst[q]) mbusy[dst[q]] = 1;
    mbusy[0] = 0;
    se.due = cyc; se.s = es;
    sq.push_back(se);
    oe.due = cyc + 1;
    for (int i = 0; i < LANES; i++) begin
      oe.a[i*W +: W] = mreg[a[i*AW +: AW]];
      oe.b[i*W +: W] = mreg[b[i*AW +: AW]];
    end
    for (int r = 0; r < NREG; r++) oe.bz[r] = mbusy[r];
    oq.push_back(oe);
  endtask

  task automatic idle();
    ra_a = '0; ra_b = '0; iss_v = '0; iss_rd = '0; wb_v = '0; wb_rd = '0; wb_data = '0;
  endtask

  // Mid-cycle reset with traffic presented while held; everything must clear
  // immediately and the held traffic must leave no trace.
  task automatic do_reset();
    @(posedge clk); #1; idle();
    @(negedge clk); #1; rs = 1'b0; #1;
    chk("rst_rd_a", 64'(rd_a), 64'd0);
    chk("rst_rd_b", 64'(rd_b), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    for (int r = 0; r < NREG; r++) begin mreg[r] = '0; mbusy[r] = 0; end
    wb_v = 2'b11; wb_rd = pa(5, 6); wb_data = pd($urandom, $urandom);
    iss_v = 2'b11; iss_rd = pa(3, 4);
    repeat (2) @(posedge clk); #1;
    chk("rst_hold_busy", 64'(busy), 64'd0);
    chk("rst_hold_rd", 64'(rd_a), 64'd0);
    idle(); #1; rs = 1'b1;
  endtask

  initial begin : monitor
    st_t  se;
    out_t oe;
    forever begin
      @(negedge clk);
      while (sq.size() > 0 && sq[0].due <= cyc) begin
        se = sq.pop_front();
        chk("stall", 64'(stall), 64'(se.s));
      end
      while (oq.size() > 0 && oq[0].due <= cyc) begin
        oe = oq.pop_front();
        chk("rd_a", 64'(rd_a), 64'(oe.a));
        chk("rd_b", 64'(rd_b), 64'(oe.b));
        chk("busy", 64'(busy), 64'(oe.bz));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin : driver
    #2 rs = 1'b0; #1;
    chk("init_rd_a", 64'(rd_a), 64'd0);
    chk("init_rd_b", 64'(rd_b), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_stall", 64'(stall), 64'd0);
    repeat (2) @(posedge clk); #2 rs = 1'b1;

    // read r5 after reset on both lanes
    step(pa(5, 5), pa(5, 5), 2'b00, '0, 2'b00, '0, '0);
    // lane0 writes r3 while lane1 reads it: bypass
    step(pa(0, 3), pa(3, 0), 2'b00, '0, 2'b01, pa(3, 0), pd(32'hDEADBEEF, 0));
    // both lanes write r7: lane1 wins
    step('0, '0, 2'b00, '0, 2'b11, pa(7, 7), pd(32'h11111111, 32'h22222222));
    step(pa(7, 3), pa(3, 7), 2'b00, '0, 2'b00, '0, '0);
    // lane0 issues rd=r4, lane1 reads r4: lane1 stalls
    step(pa(1, 4), pa(2, 0), 2'b11, pa(4, 8), 2'b00, '0, '0);
    // r4 busy; lane1 reading r4 is held off
    step(pa(0, 4), pa(0, 0), 2'b10, pa(0, 8), 2'b00, '0, '0);
    // writeback of r4 unblocks lane1 in the same cycle
    step(pa(0, 4), pa(0, 0), 2'b10, pa(0, 8), 2'b01, pa(4, 0), pd(32'h0000_0444, 0));
    // issue r9 together with wb r9: set wins
    step('0, '0, 2'b01, pa(9, 0), 2'b01, pa(9, 0), pd(32'h9999_0009, 0));
    // write r0 = all ones and issue to r0: no effect
    step('0, '0, 2'b01, pa(0, 0), 2'b01, pa(0, 0), pd(32'hFFFFFFFF, 0));
    step(pa(0, 9), pa(9, 0), 2'b00, '0, 2'b00, '0, '0);
    // hazard against busy r9 on lane0 forces lane1 (independent) to stall
    step(pa(9, 1), pa(0, 1), 2'b11, pa(10, 11), 2'b00, '0, '0);
    // set busy r2, r6 while holding data in rd_a, then reset mid-cycle
    step(pa(7, 7), pa(3, 4), 2'b11, pa(2, 6), 2'b10, pa(0, 9), pd(0, 32'h0909_0909));
    do_reset();
    // after reset: issue to r2 accepted; held writebacks to r5/r6 discarded
    step(pa(5, 6), pa(6, 5), 2'b01, pa(2, 0), 2'b00, '0, '0);
    step(pa(2, 2), pa(0, 0), 2'b10, pa(0, 12), 2'b01, pa(2, 0), pd(32'h0202_0202, 0));

    for (int n = 0; n < 300; n++) begin
      step(pa($urandom_range(0, 7), $urandom_range(0, 7)),
           pa($urandom_range(0, 7), $urandom_range(0, 7)),
           2'($urandom),
           pa($urandom_range(0, 7), $urandom_range(0, 7)),
           2'($urandom),
           pa($urandom_range(0, 7), $urandom_range(0, 7)),
           pd($urandom, $urandom));
      if (n == 150) do_reset();
    end
    @(posedge clk); #1; idle();
    repeat (3) @(negedge clk);
    chk("drain", 64'(sq.size() + oq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
